// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: captures CPU write-back register-file commits into a FIFO.
// The FIFO is drained through a first-word-fall-through valid/ready port. It
// also keeps commit and drop statistics so that any lost trace entry is visible.
//
// Optional build macro: WB_TRACE_TS_EN adds a free-running 32-bit timestamp
// to every entry. When the macro is undefined, out_ts is tied to 0.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   wb_pc/wb_rf_wen/wb_rf_addr/
//   wb_rf_wdata                   CPU write-back debug trace
//   out_valid/out_ready           drain handshake (FWFT head entry)
//   out_pc/out_addr/out_wdata/
//   out_ts                        head entry fields (0 while empty)
//   count                         occupancy 0..DEPTH
//   overflow                      sticky: at least one commit dropped
//   commit_cnt                    captured commits, including dropped ones (wraps)
//   drop_cnt                      commits dropped while full (saturates)
module wb_trace_buffer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       wb_pc,
    input  logic              wb_rf_wen,
    input  logic [4:0]        wb_rf_addr,
    input  logic [31:0]       wb_rf_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [4:0]        out_addr,
    output logic [31:0]       out_wdata,
    output logic [31:0]       out_ts,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic [31:0]       commit_cnt,
    output logic [15:0]       drop_cnt
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [31:0]       mem_pc    [DEPTH];
    logic [4:0]        mem_addr  [DEPTH];
    logic [31:0]       mem_wdata [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    logic              capture;
    logic              pop;
    logic              full;
    logic              push_ok;
    logic              drop;
    logic [CNT_W-1:0]  count_next;

    // Writes to $0 and idle cycles are not architecturally visible.
    assign capture = wb_rf_wen && (wb_rf_addr != 5'd0);
    assign pop     = out_valid && out_ready;
    assign full    = (count == CNT_W'(DEPTH));
    // When the FIFO is full, a simultaneous pop frees the slot that this push uses.
    assign push_ok = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    always_comb begin
        count_next = count;
        count_next = count + CNT_W'(push_ok) - CNT_W'(pop);
    end

    // Control state: pointers, occupancy, and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
            commit_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            count     <= count_next;
            out_valid <= (count_next != '0);
            if (push_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + ADDR_W'(1);
            if (capture) commit_cnt <= commit_cnt + 32'd1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Entry storage; the FIFO does not clear it on reset.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_pc[wr_ptr]    <= wb_pc;
            mem_addr[wr_ptr]  <= wb_rf_addr;
            mem_wdata[wr_ptr] <= wb_rf_wdata;
        end
    end

    assign out_pc    = out_valid ? mem_pc[rd_ptr]    : 32'd0;
    assign out_addr  = out_valid ? mem_addr[rd_ptr]  : 5'd0;
    assign out_wdata = out_valid ? mem_wdata[rd_ptr] : 32'd0;

`ifdef WB_TRACE_TS_EN
    logic [31:0] ts;
    logic [31:0] mem_ts [DEPTH];

    // The timestamp is 0 in the first cycle after reset and wraps freely.
    always_ff @(posedge clk) begin
        if (rst) ts <= '0;
        else     ts <= ts + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem_ts[wr_ptr] <= ts;
    end

    assign out_ts = out_valid ? mem_ts[rd_ptr] : 32'd0;
`else
    assign out_ts = 32'd0;
`endif

endmodule
